// File: rtl/pit_pkg.sv
// Shared types and constants for the 8254-style timer bus sequencer.
// Optional read-back support is selected with the PIT_READ_BACK_EN macro.
package pit_pkg;

    localparam int NUM_CNT = 3;

    typedef enum logic [1:0] {
        LATCH   = 2'b00,
        LSB     = 2'b01,
        MSB     = 2'b10,
        LSB_MSB = 2'b11
    } rw_mode_e;

    localparam logic [1:0] CTRL_ADDR    = 2'd3;
    localparam logic [1:0] READ_BACK_SC = 2'b11;

    localparam logic [1:0] SC_CNT0 = 2'd0;
    localparam logic [1:0] SC_CNT1 = 2'd1;
    localparam logic [1:0] SC_CNT2 = 2'd2;
    localparam logic [1:0] SC_CNT [NUM_CNT] = '{SC_CNT0, SC_CNT1, SC_CNT2};

endpackage

// File: rtl/pit_byte_sequencer.sv
// Per-counter byte sequencing: RW mode, write/read byte pointers, status-pending
// flag (PIT_READ_BACK_EN only) and the registered one-cycle strobes of one counter.
module pit_byte_sequencer
    import pit_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_ctrl_wr,
    input  rw_mode_e i_rw_mode,
    input  logic     i_latch,
    input  logic     i_status_set,
    input  logic     i_data_wr,
    input  logic     i_data_rd,
    output logic     o_ctrl_wr,
    output logic     o_cr_lsb_wr,
    output logic     o_cr_msb_wr,
    output logic     o_load_done,
    output logic     o_count_latch,
    output logic     o_ol_release,
    output rw_mode_e o_rw_mode,
    output logic     o_rd_msb,
    output logic     o_status_pending
);

    rw_mode_e r_rw_mode;
    logic     r_wr_msb;
    logic     r_rd_msb;
    logic     r_ctrl_wr;
    logic     r_cr_lsb_wr;
    logic     r_cr_msb_wr;
    logic     r_load_done;
    logic     r_count_latch;
    logic     r_ol_release;
    logic     w_status_pending;

`ifdef PIT_READ_BACK_EN
    logic r_status_pending;

    // Status byte is read in place of the count until one read consumes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status_pending <= 1'b0;
        end else if (i_status_set) begin
            r_status_pending <= 1'b1;
        end else if (i_data_rd) begin
            r_status_pending <= 1'b0;
        end else begin
            r_status_pending <= r_status_pending;
        end
    end
    assign w_status_pending = r_status_pending;
`else
    logic w_unused_status_set;
    assign w_unused_status_set = i_status_set;
    assign w_status_pending    = 1'b0;
`endif

    // Mode/pointer state and one-cycle strobes, registered the cycle after commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rw_mode     <= LATCH;
            r_wr_msb      <= 1'b0;
            r_rd_msb      <= 1'b0;
            r_ctrl_wr     <= 1'b0;
            r_cr_lsb_wr   <= 1'b0;
            r_cr_msb_wr   <= 1'b0;
            r_load_done   <= 1'b0;
            r_count_latch <= 1'b0;
            r_ol_release  <= 1'b0;
        end else begin
            r_ctrl_wr     <= 1'b0;
            r_cr_lsb_wr   <= 1'b0;
            r_cr_msb_wr   <= 1'b0;
            r_load_done   <= 1'b0;
            r_ol_release  <= 1'b0;
            r_count_latch <= i_latch;
            if (i_ctrl_wr) begin
                r_rw_mode <= i_rw_mode;
                r_wr_msb  <= 1'b0;
                r_rd_msb  <= 1'b0;
                r_ctrl_wr <= 1'b1;
            end else if (i_data_wr) begin
                case (r_rw_mode)
                    LSB: begin
                        r_cr_lsb_wr <= 1'b1;
                        r_load_done <= 1'b1;
                    end
                    MSB: begin
                        r_cr_msb_wr <= 1'b1;
                        r_load_done <= 1'b1;
                    end
                    LSB_MSB: begin
                        r_wr_msb    <= ~r_wr_msb;
                        r_cr_lsb_wr <= ~r_wr_msb;
                        r_cr_msb_wr <= r_wr_msb;
                        r_load_done <= r_wr_msb;
                    end
                    default: ;
                endcase
            end else if (i_data_rd && !w_status_pending) begin
                case (r_rw_mode)
                    LSB, MSB: r_ol_release <= 1'b1;
                    LSB_MSB: begin
                        r_rd_msb     <= ~r_rd_msb;
                        r_ol_release <= r_rd_msb;
                    end
                    default: ;
                endcase
            end else begin
                r_rw_mode <= r_rw_mode;
            end
        end
    end

    assign o_ctrl_wr        = r_ctrl_wr;
    assign o_cr_lsb_wr      = r_cr_lsb_wr;
    assign o_cr_msb_wr      = r_cr_msb_wr;
    assign o_load_done      = r_load_done;
    assign o_count_latch    = r_count_latch;
    assign o_ol_release     = r_ol_release;
    assign o_rw_mode        = r_rw_mode;
    assign o_rd_msb         = r_rd_msb;
    assign o_status_pending = w_status_pending;

endmodule

// File: rtl/pit_bus_sequencer.sv
// Bus decode and read-data mux for the three-counter timer.
// Read-back command support is enabled by defining PIT_READ_BACK_EN.
module pit_bus_sequencer
    import pit_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cs_n,
    input  logic                   i_rd_n,
    input  logic                   i_wr_n,
    input  logic [1:0]             i_addr,
    input  logic [7:0]             i_din,
    output logic [7:0]             o_dout,
    output logic                   o_dout_oe,
    input  logic [16*NUM_CNT-1:0]  i_ol_data,
    input  logic [8*NUM_CNT-1:0]   i_status,
    output logic [NUM_CNT-1:0]     o_ctrl_wr,
    output logic [7:0]             o_ctrl_word,
    output logic [NUM_CNT-1:0]     o_cr_lsb_wr,
    output logic [NUM_CNT-1:0]     o_cr_msb_wr,
    output logic [7:0]             o_cr_data,
    output logic [NUM_CNT-1:0]     o_load_done,
    output logic [NUM_CNT-1:0]     o_count_latch,
    output logic [NUM_CNT-1:0]     o_ol_release
);

    logic       r_cs_n_q;
    logic       r_rd_n_q;
    logic       r_wr_n_q;
    logic [1:0] r_addr_q;
    logic [7:0] r_din_q;
    logic [7:0] r_ctrl_word;
    logic [7:0] r_cr_data;

    logic               w_wr_commit;
    logic               w_rd_commit;
    logic               w_ctrl_cmd;
    logic               w_rb_cmd;
    logic [1:0]         w_sc;
    logic               w_cr_load;
    logic [NUM_CNT-1:0] w_ctrl_wr;
    logic [NUM_CNT-1:0] w_latch;
    logic [NUM_CNT-1:0] w_status_set;
    logic [NUM_CNT-1:0] w_data_wr;
    logic [NUM_CNT-1:0] w_data_rd;
    logic [NUM_CNT-1:0] w_rd_msb;
    logic [NUM_CNT-1:0] w_status_pending;
    rw_mode_e           w_rw_mode [NUM_CNT];

    logic               w_dout_oe;
    logic [7:0]         w_dout;
    logic [1:0]         w_idx;
    logic [15:0]        w_sel_ol;

    // Commit detection on strobe rising edges and per-counter command decode
    always_comb begin
        w_wr_commit = !r_wr_n_q && i_wr_n && !r_cs_n_q && r_rd_n_q;
        w_rd_commit = !r_rd_n_q && i_rd_n && !r_cs_n_q && r_wr_n_q;
        w_ctrl_cmd  = w_wr_commit && (r_addr_q == CTRL_ADDR);
        w_sc        = r_din_q[7:6];
`ifdef PIT_READ_BACK_EN
        w_rb_cmd    = w_ctrl_cmd && (w_sc == READ_BACK_SC);
`else
        w_rb_cmd    = 1'b0;
`endif
        w_cr_load   = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) begin
            w_ctrl_wr[k]    = w_ctrl_cmd && (w_sc == SC_CNT[k]) && (r_din_q[5:4] != 2'b00);
            w_latch[k]      = (w_ctrl_cmd && (w_sc == SC_CNT[k]) && (r_din_q[5:4] == 2'b00))
                            || (w_rb_cmd && !r_din_q[5] && r_din_q[k+1]);
            w_status_set[k] = w_rb_cmd && !r_din_q[4] && r_din_q[k+1];
            w_data_wr[k]    = w_wr_commit && (r_addr_q == 2'(k));
            w_data_rd[k]    = w_rd_commit && (r_addr_q == 2'(k));
            w_cr_load       = w_cr_load || (w_data_wr[k] && (w_rw_mode[k] != LATCH));
        end
    end

    // Sampled bus strobes (reset to idle so release cannot fake a commit) and held bytes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_n_q    <= 1'b1;
            r_rd_n_q    <= 1'b1;
            r_wr_n_q    <= 1'b1;
            r_addr_q    <= 2'd0;
            r_din_q     <= 8'h00;
            r_ctrl_word <= 8'h00;
            r_cr_data   <= 8'h00;
        end else begin
            r_cs_n_q    <= i_cs_n;
            r_rd_n_q    <= i_rd_n;
            r_wr_n_q    <= i_wr_n;
            r_addr_q    <= i_addr;
            r_din_q     <= i_din;
            r_ctrl_word <= (|w_ctrl_wr) ? r_din_q : r_ctrl_word;
            r_cr_data   <= w_cr_load ? r_din_q : r_cr_data;
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        pit_byte_sequencer u_seq (
            .i_clk            (i_clk),
            .i_rst            (i_rst),
            .i_ctrl_wr        (w_ctrl_wr[g]),
            .i_rw_mode        (rw_mode_e'(r_din_q[5:4])),
            .i_latch          (w_latch[g]),
            .i_status_set     (w_status_set[g]),
            .i_data_wr        (w_data_wr[g]),
            .i_data_rd        (w_data_rd[g]),
            .o_ctrl_wr        (o_ctrl_wr[g]),
            .o_cr_lsb_wr      (o_cr_lsb_wr[g]),
            .o_cr_msb_wr      (o_cr_msb_wr[g]),
            .o_load_done      (o_load_done[g]),
            .o_count_latch    (o_count_latch[g]),
            .o_ol_release     (o_ol_release[g]),
            .o_rw_mode        (w_rw_mode[g]),
            .o_rd_msb         (w_rd_msb[g]),
            .o_status_pending (w_status_pending[g])
        );
    end

`ifndef PIT_READ_BACK_EN
    logic w_unused_status;
    assign w_unused_status = ^{i_status, w_status_pending};
`endif

    // Read-data mux; the control port index is folded onto counter 0 but never driven
    always_comb begin
        w_dout_oe = !i_cs_n && !i_rd_n && i_wr_n && (i_addr != CTRL_ADDR);
        w_idx     = (i_addr == CTRL_ADDR) ? 2'd0 : i_addr;
        w_sel_ol  = i_ol_data[{w_idx, 4'h0} +: 16];
        if (!w_dout_oe) begin
            w_dout = 8'h00;
`ifdef PIT_READ_BACK_EN
        end else if (w_status_pending[w_idx]) begin
            w_dout = i_status[{w_idx, 3'b000} +: 8];
`endif
        end else begin
            case (w_rw_mode[w_idx])
                MSB:     w_dout = w_sel_ol[15:8];
                LSB_MSB: w_dout = w_rd_msb[w_idx] ? w_sel_ol[15:8] : w_sel_ol[7:0];
                default: w_dout = w_sel_ol[7:0];
            endcase
        end
    end

    assign o_dout      = w_dout;
    assign o_dout_oe   = w_dout_oe;
    assign o_ctrl_word = r_ctrl_word;
    assign o_cr_data   = r_cr_data;

endmodule

// File: tb/tb_pit_bus_sequencer.sv
// Directed scoreboard bench for pit_bus_sequencer; covers both PIT_READ_BACK_EN builds.
module tb_pit_bus_sequencer;
    import pit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cs_n, rd_n, wr_n;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [47:0] ol_data;
    logic [23:0] status;
    logic [2:0]  ctrl_wr, lsb_wr, msb_wr, load_done, count_latch, ol_release;
    logic [7:0]  ctrl_word, cr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [17:0] strb;
        logic [15:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] m_cw = 8'h00;
    logic [7:0] m_cd = 8'h00;

    always #5 clk = ~clk;

    pit_bus_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
        .i_addr(addr), .i_din(din), .o_dout(dout), .o_dout_oe(dout_oe),
        .i_ol_data(ol_data), .i_status(status),
        .o_ctrl_wr(ctrl_wr), .o_ctrl_word(ctrl_word),
        .o_cr_lsb_wr(lsb_wr), .o_cr_msb_wr(msb_wr), .o_cr_data(cr_data),
        .o_load_done(load_done), .o_count_latch(count_latch), .o_ol_release(ol_release)
    );

    function automatic logic [17:0] mk(input logic [2:0] c, l, m, d, q, r);
        return {c, l, m, d, q, r};
    endfunction

    // Strobe monitor: record every cycle with any strobe active
    always @(negedge clk) begin
        if ({ctrl_wr, lsb_wr, msb_wr, load_done, count_latch, ol_release} != 18'h0) begin
            obs_q.push_back('{"obs", {ctrl_wr, lsb_wr, msb_wr, load_done, count_latch, ol_release},
                              {ctrl_word, cr_data}});
        end
    end

    task automatic expect_ev(input string tag, input logic [17:0] s);
        ev_t e;
        e.tag  = tag;
        e.strb = s;
        e.data = {m_cw, m_cd};
        exp_q.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        ev_t e, o;
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (obs_q.size() != 0) else begin
                errors++;
                $error("FAIL %s missing event observed none expected strb=%h data=%h", e.tag, e.strb, e.data);
            end
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                checks++;
                assert ({o.strb, o.data} === {e.strb, e.data}) else begin
                    errors++;
                    $error("FAIL %s observed strb=%h data=%h expected strb=%h data=%h",
                           e.tag, o.strb, o.data, e.strb, e.data);
                end
            end
        end
        checks++;
        assert (obs_q.size() == 0) else begin
            errors++;
            $error("FAIL %s extra events observed %0d (first strb=%h) expected 0", tag, obs_q.size(), obs_q[0].strb);
            obs_q.delete();
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs_n = 1'b0; addr = a; din = d; wr_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic do_read(input string tag, input logic [1:0] a, input logic [7:0] e_byte);
        logic [7:0] d, x;
        logic       oe;
        rd_exp_q.push_back(e_byte);
        @(posedge clk); #1;
        cs_n = 1'b0; addr = a; rd_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d  = dout;
        oe = dout_oe;
        @(posedge clk); #1;
        rd_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b1;
        x = rd_exp_q.pop_front();
        checks++;
        assert (d === x) else begin
            errors++;
            $error("FAIL %s dout observed %h expected %h", tag, d, x);
        end
        checks++;
        assert (oe === (a != CTRL_ADDR)) else begin
            errors++;
            $error("FAIL %s dout_oe observed %b expected %b", tag, oe, (a != CTRL_ADDR));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; din = 8'h00;
        ol_data = {16'hBEEF, 16'h5678, 16'h1234};
        status  = {8'h00, 8'h00, 8'h36};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; assert (dout === 8'h00) else begin errors++; $error("FAIL rst_dout observed %h expected 00", dout); end
        checks++; assert (dout_oe === 1'b0) else begin errors++; $error("FAIL rst_oe observed %b expected 0", dout_oe); end
        checks++; assert (ctrl_word === 8'h00) else begin errors++; $error("FAIL rst_cw observed %h expected 00", ctrl_word); end
        checks++; assert (cr_data === 8'h00) else begin errors++; $error("FAIL rst_cd observed %h expected 00", cr_data); end
        checks++; assert ({ctrl_wr, lsb_wr, msb_wr, load_done, count_latch, ol_release} === 18'h0) else begin
            errors++; $error("FAIL rst_strb observed %h expected 0", {ctrl_wr, lsb_wr, msb_wr, load_done, count_latch, ol_release}); end
        @(posedge clk); #1;
        rst = 1'b0;
        check_sb("post_reset");

        // Counter 0, LSB then MSB
        m_cw = 8'h30; expect_ev("ctrl30", mk(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd3, 8'h30); check_sb("ctrl30");
        m_cd = 8'h34; expect_ev("c0_lsb", mk(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd0, 8'h34); check_sb("c0_lsb");
        m_cd = 8'h12; expect_ev("c0_msb", mk(3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000));
        bus_write(2'd0, 8'h12); check_sb("c0_msb");

        // Counter 1, LSB only
        m_cw = 8'h50; expect_ev("ctrl50", mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd3, 8'h50); check_sb("ctrl50");
        for (int i = 0; i < 3; i++) begin
            m_cd = 8'h11 * 8'(i + 1);
            expect_ev("c1_lsb", mk(3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000));
            bus_write(2'd1, m_cd);
            check_sb("c1_lsb");
        end

        // Counter 2, two-byte read
        m_cw = 8'hB0; expect_ev("ctrlB0", mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd3, 8'hB0); check_sb("ctrlB0");
        do_read("c2_rd_lsb", 2'd2, 8'hEF); check_sb("c2_rd_lsb");
        expect_ev("c2_release", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100));
        do_read("c2_rd_msb", 2'd2, 8'hBE); check_sb("c2_rd_msb");

        // Latch command keeps counter 0 in mode 11
        expect_ev("latch0", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000));
        bus_write(2'd3, 8'h00); check_sb("latch0");
        m_cd = 8'h55; expect_ev("c0_lsb2", mk(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd0, 8'h55); check_sb("c0_lsb2");
        m_cd = 8'h66; expect_ev("c0_msb2", mk(3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000));
        bus_write(2'd0, 8'h66); check_sb("c0_msb2");

        // rd_n and wr_n low together: no commit, pointer untouched
        @(posedge clk); #1;
        cs_n = 1'b0; addr = 2'd2; din = 8'h99; wr_n = 1'b0; rd_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b1;
        check_sb("both_low");
        do_read("c2_after_both", 2'd2, 8'hEF); check_sb("c2_after_both");
        expect_ev("c2_release2", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100));
        do_read("c2_rd_msb2", 2'd2, 8'hBE); check_sb("c2_rd_msb2");

        // Control port is never driven
        do_read("ctrl_port_rd", 2'd3, 8'h00);

`ifdef PIT_READ_BACK_EN
        expect_ev("rb_c2", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000));
        bus_write(2'd3, 8'hC2); check_sb("rb_c2");
        do_read("rb_status", 2'd0, 8'h36);
        do_read("rb_lsb", 2'd0, 8'h34); check_sb("rb_lsb");
        expect_ev("rb_release", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
        do_read("rb_msb", 2'd0, 8'h12); check_sb("rb_msb");
        bus_write(2'd3, 8'hE2);
        bus_write(2'd3, 8'hE2); check_sb("rb_e2_twice");
        do_read("rb2_status", 2'd0, 8'h36);
        do_read("rb2_lsb", 2'd0, 8'h34); check_sb("rb2_lsb");
        expect_ev("rb2_release", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
        do_read("rb2_msb", 2'd0, 8'h12); check_sb("rb2_msb");
`else
        bus_write(2'd3, 8'hC2); check_sb("rb_ignored");
        do_read("nrb_lsb", 2'd0, 8'h34); check_sb("nrb_lsb");
        expect_ev("nrb_release", mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
        do_read("nrb_msb", 2'd0, 8'h12); check_sb("nrb_msb");
`endif

        // Reset between LSB and MSB in mode 11
        m_cd = 8'hAA; expect_ev("c0_lsb3", mk(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd0, 8'hAA); check_sb("c0_lsb3");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        m_cw = 8'h00;
        m_cd = 8'h00;
        checks++; assert (ctrl_word === m_cw) else begin errors++; $error("FAIL rst2_cw observed %h expected %h", ctrl_word, m_cw); end
        checks++; assert (cr_data === m_cd) else begin errors++; $error("FAIL rst2_cd observed %h expected %h", cr_data, m_cd); end
        bus_write(2'd0, 8'hBB); check_sb("post_rst_ignored");

        // Reset landing on the commit cycle discards the access
        @(posedge clk); #1;
        cs_n = 1'b0; addr = 2'd3; din = 8'h30; wr_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cs_n = 1'b1;
        check_sb("rst_mid_access");
        bus_write(2'd0, 8'hCC); check_sb("still_unprogrammed");
        m_cw = 8'h30; expect_ev("ctrl30b", mk(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd3, 8'h30); check_sb("ctrl30b");
        m_cd = 8'h77; expect_ev("c0_lsb4", mk(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
        bus_write(2'd0, 8'h77); check_sb("c0_lsb4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
